// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, key legend map and state/frame-class encodings for the keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  // Indexed row*NUM_COLS+col; entry 0 is row 0, col 0.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_e;
endpackage

// File: rtl/keypad_frame_scanner.sv
// keypad_frame_scanner: drives one active-low column at a time, samples synchronized rows at the end
// of each column period and presents a 16-bit pressed snapshot with a one-cycle frame_done.
module keypad_frame_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD_CYCLES = 100_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] frame_vec,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_PERIOD_CYCLES);
  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   vec_q, vec_d;
  logic          done_q, done_d;
  logic          tc;
  assign tc = cnt_q == CW'(SCAN_PERIOD_CYCLES - 1);
  always_comb begin
    cnt_d  = tc ? '0 : cnt_q + 1'b1;
    col_d  = tc ? col_q + 2'd1 : col_q;
    done_d = tc && (col_q == 2'd3);
    vec_d  = vec_q;
    if (tc)
      for (int r = 0; r < NUM_ROWS; r++) vec_d[r*NUM_COLS + int'(col_q)] = ~sync2_q[r];
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      cnt_q   <= '0;
      col_q   <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= rows;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
    end
  end
  assign cols       = ~(4'b0001 << col_q);
  assign frame_vec  = vec_q;
  assign frame_done = done_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: classifies scanned frames, debounces presses/releases and hands one event per
// press to the consumer over a valid/ready handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD_CYCLES = 100_000,
  parameter int DEBOUNCE_FRAMES    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_overrun
);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  logic [15:0]  frame_vec;
  logic         frame_done;
  frame_class_e cls;
  logic [3:0]   idx, code;
  state_e       state_q, state_d;
  logic [3:0]   cand_q, cand_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic         last, same, ev, drop;
  logic [3:0]   code_q, code_d;
  logic         valid_q, valid_d, ovr_q, ovr_d;

  keypad_frame_scanner #(.SCAN_PERIOD_CYCLES(SCAN_PERIOD_CYCLES)) u_scan (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rows      (rows),
    .cols      (cols),
    .frame_vec (frame_vec),
    .frame_done(frame_done)
  );

  always_comb begin
    idx = '0;
    cls = (frame_vec == '0) ? NONE : (((frame_vec & (frame_vec - 16'd1)) == '0) ? SINGLE : MULTI);
    for (int i = 0; i < 16; i++) if (frame_vec[i]) idx = 4'(i);
  end
  assign code    = KEY_MAP[idx];
  assign cnt_inc = cnt_q + 1'b1;
  assign last    = cnt_inc == DW'(DEBOUNCE_FRAMES);
  assign same    = (cls == SINGLE) && (code == cand_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    ev      = 1'b0;
    if (frame_done)
      case (state_q)
        IDLE:
          if (cls == SINGLE) begin
            cand_d  = code;
            cnt_d   = DW'(1);
            state_d = PRESS_DB;
          end
        PRESS_DB:
          if (same) begin
            cnt_d   = cnt_inc;
            state_d = last ? PRESSED : PRESS_DB;
            ev      = last;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        PRESSED:
          if (cls == NONE) begin
            cnt_d   = DW'(1);
            state_d = RELEASE_DB;
          end
        RELEASE_DB:
          if (cls == NONE) begin
            cnt_d   = last ? '0 : cnt_inc;
            state_d = last ? IDLE : RELEASE_DB;
          end else begin
            state_d = PRESSED;
          end
        default: state_d = IDLE;
      endcase
  end

  // A pending unconsumed event wins; a simultaneous handshake frees the slot for the new one.
  assign drop    = ev && valid_q && !key_ready;
  assign code_d  = (ev && !drop) ? cand_q : code_q;
  assign valid_d = ev || (valid_q && !key_ready);
  assign ovr_d   = drop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_overrun = ovr_q;
  assign key_held    = (state_q == PRESSED) || (state_q == RELEASE_DB);
endmodule
